game_scheduler: RTL
===================

# game_scheduler

Top-level pacing controller that sequences the horizon datapath: turns the raw per-frame tick into `update` pulses, owns game speed and the animation timer, and gates obstacle generation during the opening clear period. It also drives the start/crash/restart lifecycle, including the restart reset pulse for the horizon and its children. It sits between the video timing/keyboard inputs and the horizon, collision and score blocks.

## Interface
Parameters:
- INIT_SPEED, 6144 — starting speed, ×1024 fixed point (6.0).
- MAX_SPEED, 13312 — speed ceiling (13.0).
- ACCEL, 1 — speed increment per running frame.
- CLEAR_FRAMES, 180 — running frames before `has_obstacles` rises.
- RESTART_FRAMES, 30 — post-crash lockout frames before restart is accepted.
- UPDATE_GAP, 8 — minimum cycles between `update` pulses; covers the horizon's 7-cycle update sequence.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- jump_key  in  1  debounced level, start/restart request.
- crash_in  in  1  collision detector result, level.
- start  out  1  one-cycle pulse on game start.
- crash  out  1  level, high while CRASHED.
- game_rst  out  1  one-cycle restart pulse, ORed with rst for the horizon and its children.
- update  out  1  one-cycle per-frame update strobe.
- timer  out  6  frame counter, mod 60.
- speed  out  15  current speed, ×1024.
- has_obstacles  out  1  obstacle generation enable.
- distance  out  15  distance travelled: accumulator bits [24:10].

## Operation
- States: IDLE, STARTING, RUNNING, CRASHED, LOCKED, RESTART.
- IDLE: wait for `jump_key` = 1, then go to STARTING.
- STARTING: one cycle. `start` = 1, load `speed` = INIT_SPEED, clear the timer, clear-frame counter and distance accumulator. Next state RUNNING.
- RUNNING, on an accepted `frame_tick`:
  - `update` pulses.
  - `timer` = (timer+1) mod 60.
  - `speed` = min(speed+ACCEL, MAX_SPEED), saturating; no wrap.
  - 25-bit accumulator += speed, wrapping.
  - clear counter increments, saturating at CLEAR_FRAMES; `has_obstacles` = (counter == CLEAR_FRAMES).
- Tick acceptance: a `frame_tick` is dropped if fewer than UPDATE_GAP cycles have elapsed since the last `update`. A dropped tick changes no state.
- `crash_in` = 1 in RUNNING: go to CRASHED. Crash has priority over a same-cycle `frame_tick` (no update, no speed/timer change). `speed`, `timer`, `distance` and `has_obstacles` freeze.
- CRASHED: `crash` = 1. Counts frame_ticks; after RESTART_FRAMES ticks go to LOCKED.
- LOCKED: `crash` still 1. Waits for `jump_key` to be low, then high (rising edge required), then go to RESTART.
- RESTART: one cycle. `game_rst` = 1, `crash` = 0; all counters and `speed` reset to their reset values. Next state STARTING, so a restart starts the game without a second keypress.
- `jump_key` held through a crash never auto-restarts (edge rule above).

## Timing
- Reset values: state IDLE; `start`, `crash`, `game_rst`, `update`, `has_obstacles` = 0; `timer` = 0; `speed` = INIT_SPEED; `distance` = 0; gap counter saturated (first tick accepted).
- Outputs are registered.
- `update` is high the cycle after `frame_tick` is sampled. `timer`, `speed` and `distance` show their new values in the same cycle that `update` is high.
- `start` is high 1 cycle after `jump_key` is first sampled high in IDLE; RUNNING begins the following cycle.
- `crash` rises 1 cycle after `crash_in` is sampled.
- `rst` mid-operation takes effect next edge from any state and overrides all inputs.
- `frame_tick` arriving during STARTING or RESTART is ignored.

## Structure
- Shared package `game_pkg`: `state_t` enum, speed scale 1024, timer modulus 60, default parameter constants.
- One sub-module, `speed_ramp`: saturating speed register plus distance accumulator, with load and step inputs.

## Test plan
- Reset then `jump_key`=1 → `start` pulse 1 cycle later; `speed`=6144, `timer`=0.
- 100 frame_ticks 1000 cycles apart → 100 `update` pulses; `timer`=40, `speed`=6244; `has_obstacles`=0 throughout. Tick 180 → `has_obstacles`=1 in the same cycle as that `update`.
- Two frame_ticks 3 cycles apart → one `update`; `timer` advances by 1 only.
- With MAX_SPEED=6150, run 10 ticks → `speed` saturates at 6150 and stays there.
- `crash_in` and `frame_tick` in the same cycle → no `update`; `crash`=1 next cycle; `timer`, `speed`, `distance` unchanged.
- `jump_key` held high through the crash, then 30 ticks → no restart. Release then press → `game_rst` pulse, then `start` pulse the next cycle, `speed`=6144, `distance`=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game pacing controller and its speed datapath.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STARTING,
        RUNNING,
        CRASHED,
        LOCKED,
        RESTART
    } state_t;

    localparam int SPEED_SCALE = 1024;
    localparam int TIMER_MOD   = 60;

    localparam int SPEED_W  = 15;
    localparam int TIMER_W  = 6;
    localparam int ACC_W    = 25;
    localparam int DIST_LSB = $clog2(SPEED_SCALE);

    localparam int DEF_INIT_SPEED     = 6144;
    localparam int DEF_MAX_SPEED      = 13312;
    localparam int DEF_ACCEL          = 1;
    localparam int DEF_CLEAR_FRAMES   = 180;
    localparam int DEF_RESTART_FRAMES = 30;
    localparam int DEF_UPDATE_GAP     = 8;

endpackage

// File: rtl/speed_ramp.sv
// Saturating game speed register and wrapping distance accumulator.
module speed_ramp
    import game_pkg::*;
#(
    parameter int INIT_SPEED = DEF_INIT_SPEED,
    parameter int MAX_SPEED  = DEF_MAX_SPEED,
    parameter int ACCEL      = DEF_ACCEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    output logic [SPEED_W-1:0] speed_o,
    output logic [SPEED_W-1:0] distance_o
);

    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SPEED_W:0]   sum;

    // Distance integrates the already-stepped speed, so each frame's advance matches the speed shown with it.
    always_comb begin
        sum     = {1'b0, speed_q} + (SPEED_W + 1)'(ACCEL);
        speed_d = speed_q;
        acc_d   = acc_q;
        if (load_i) begin
            speed_d = SPEED_W'(INIT_SPEED);
            acc_d   = '0;
        end else if (step_i) begin
            speed_d = (sum >= (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : sum[SPEED_W-1:0];
            acc_d   = acc_q + ACC_W'(speed_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= SPEED_W'(INIT_SPEED);
            acc_q   <= '0;
        end else begin
            speed_q <= speed_d;
            acc_q   <= acc_d;
        end
    end

    assign speed_o    = speed_q;
    assign distance_o = acc_q[DIST_LSB +: SPEED_W];

endmodule

// File: rtl/game_scheduler.sv
// Pacing controller: turns frame ticks into update strobes and runs the start/crash/restart lifecycle.
module game_scheduler
    import game_pkg::*;
#(
    parameter int INIT_SPEED     = DEF_INIT_SPEED,
    parameter int MAX_SPEED      = DEF_MAX_SPEED,
    parameter int ACCEL          = DEF_ACCEL,
    parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
    parameter int RESTART_FRAMES = DEF_RESTART_FRAMES,
    parameter int UPDATE_GAP     = DEF_UPDATE_GAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               jump_key,
    input  logic               crash_in,
    output logic               start,
    output logic               crash,
    output logic               game_rst,
    output logic               update,
    output logic [TIMER_W-1:0] timer,
    output logic [SPEED_W-1:0] speed,
    output logic               has_obstacles,
    output logic [SPEED_W-1:0] distance
);

    localparam int GAP_W = $clog2(UPDATE_GAP + 1);
    localparam int CLR_W = $clog2(CLEAR_FRAMES + 1);
    localparam int RST_W = $clog2(RESTART_FRAMES + 1);

    localparam logic [GAP_W-1:0]   GAP_SAT    = GAP_W'(UPDATE_GAP);
    localparam logic [CLR_W-1:0]   CLEAR_MAX  = CLR_W'(CLEAR_FRAMES);
    localparam logic [RST_W-1:0]   LOCK_LAST  = RST_W'(RESTART_FRAMES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_MOD - 1);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CLR_W-1:0]   clear_q, clear_d;
    logic [RST_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               seen_low_q, seen_low_d;
    logic               start_q, start_d;
    logic               crash_q, crash_d;
    logic               game_rst_q, game_rst_d;
    logic               update_q, update_d;
    logic               has_obs_q, has_obs_d;
    logic               step, load;

    // Crash outranks a same-cycle tick; gap_q counts cycles since the last update, with the update cycle as 1.
    always_comb begin
        state_d    = state_q;
        step       = 1'b0;
        lock_cnt_d = lock_cnt_q;
        seen_low_d = 1'b0;
        case (state_q)
            IDLE:     if (jump_key) state_d = STARTING;
            STARTING: state_d = RUNNING;
            RUNNING: begin
                if (crash_in) begin
                    state_d    = CRASHED;
                    lock_cnt_d = '0;
                end else if (frame_tick && (gap_q >= GAP_SAT)) begin
                    step = 1'b1;
                end
            end
            CRASHED: begin
                if (frame_tick) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    if (lock_cnt_q == LOCK_LAST) state_d = LOCKED;
                end
            end
            LOCKED: begin
                seen_low_d = seen_low_q | ~jump_key;
                if (seen_low_q && jump_key) state_d = RESTART;
            end
            RESTART:  state_d = STARTING;
            default:  state_d = IDLE;
        endcase

        load = (state_d == STARTING) || (state_d == RESTART);

        gap_d = gap_q;
        if (state_d == RESTART)   gap_d = GAP_SAT;
        else if (step)            gap_d = GAP_W'(1);
        else if (gap_q < GAP_SAT) gap_d = gap_q + 1'b1;

        clear_d = clear_q;
        timer_d = timer_q;
        if (load) begin
            clear_d = '0;
            timer_d = '0;
        end else if (step) begin
            if (clear_q != CLEAR_MAX) clear_d = clear_q + 1'b1;
            timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
        end

        start_d    = (state_d == STARTING);
        crash_d    = (state_d == CRASHED) || (state_d == LOCKED);
        game_rst_d = (state_d == RESTART);
        update_d   = step;
        has_obs_d  = (clear_d == CLEAR_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_q      <= GAP_SAT;
            clear_q    <= '0;
            lock_cnt_q <= '0;
            timer_q    <= '0;
            seen_low_q <= 1'b0;
            start_q    <= 1'b0;
            crash_q    <= 1'b0;
            game_rst_q <= 1'b0;
            update_q   <= 1'b0;
            has_obs_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            clear_q    <= clear_d;
            lock_cnt_q <= lock_cnt_d;
            timer_q    <= timer_d;
            seen_low_q <= seen_low_d;
            start_q    <= start_d;
            crash_q    <= crash_d;
            game_rst_q <= game_rst_d;
            update_q   <= update_d;
            has_obs_q  <= has_obs_d;
        end
    end

    speed_ramp #(
        .INIT_SPEED (INIT_SPEED),
        .MAX_SPEED  (MAX_SPEED),
        .ACCEL      (ACCEL)
    ) u_speed_ramp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .speed_o    (speed),
        .distance_o (distance)
    );

    assign start         = start_q;
    assign crash         = crash_q;
    assign game_rst      = game_rst_q;
    assign update        = update_q;
    assign timer         = timer_q;
    assign has_obstacles = has_obs_q;

endmodule
